// File: rtl/lock_sequencer.sv
// lock_sequencer: control FSM sequencing the 4-digit combination-lock datapath with timeout and lockout
module lock_sequencer #(
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter int          TIMEOUT_CYCLES = 500,
  parameter logic [15:0] CYPHER_DEFAULT = 16'h0000,
  parameter int          CNT_W          = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  digit_in,
  input  logic        digit_strobe,
  input  logic        cypher_load,
  input  logic [15:0] cypher_in,
  input  logic        relock,
  input  logic        dp_valid,
  input  logic        dp_invalid,
  input  logic        dp_restart,
  input  logic        dp_final,
  output logic [2:0]  control_out,
  output logic [3:0]  digit_out,
  output logic [15:0] cypher_out,
  output logic        dp_read,
  output logic [2:0]  stage,
  output logic [3:0]  fail_count,
  output logic        unlocked,
  output logic        locked_out,
  output logic        busy
);
  typedef enum logic [2:0] {WAIT, CHECK, EVAL, UNLOCKED, LOCKOUT} state_t;
  state_t state;
  logic [CNT_W-1:0] timer, lock_cnt;
  logic [3:0] fail_next;
  logic unused_ok;
  assign unused_ok = dp_invalid;
  assign fail_next = fail_count == 4'hF ? 4'hF : fail_count + 4'd1;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= WAIT;
      stage       <= 3'd1;
      control_out <= 3'd0;
      digit_out   <= 4'd0;
      dp_read     <= 1'b0;
      cypher_out  <= CYPHER_DEFAULT;
      fail_count  <= 4'd0;
      timer       <= '0;
      lock_cnt    <= '0;
      unlocked    <= 1'b0;
      locked_out  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (digit_strobe) begin
            digit_out   <= digit_in;
            control_out <= stage;
            dp_read     <= 1'b1;
            busy        <= 1'b1;
            timer       <= '0;
            state       <= CHECK;
          end else begin
            if (cypher_load && stage == 3'd1) cypher_out <= cypher_in;
            if (stage > 3'd1) begin
              if (timer >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
                stage <= 3'd1;
                timer <= '0;
              end else timer <= timer + CNT_W'(1);
            end else timer <= '0;
          end
        end
        CHECK: begin
          control_out <= 3'd0;
          dp_read     <= 1'b0;
          state       <= EVAL;
        end
        EVAL: begin
          busy <= 1'b0;
          if (stage == 3'd4 && dp_final) begin
            unlocked   <= 1'b1;
            stage      <= 3'd1;
            fail_count <= 4'd0;
            state      <= UNLOCKED;
          end else if (stage < 3'd4 && dp_valid) begin
            stage <= stage + 3'd1;
            state <= WAIT;
          end else if (stage >= 3'd2 && dp_restart) begin
            // the rejected digit equals digit 1, so it already starts a new attempt
            stage <= 3'd2;
            state <= WAIT;
          end else begin
            stage      <= 3'd1;
            fail_count <= fail_next;
            if (fail_next == 4'(MAX_FAIL)) begin
              locked_out <= 1'b1;
              lock_cnt   <= '0;
              state      <= LOCKOUT;
            end else state <= WAIT;
          end
        end
        UNLOCKED: begin
          if (cypher_load) cypher_out <= cypher_in;
          if (relock) begin
            unlocked <= 1'b0;
            state    <= WAIT;
          end
        end
        LOCKOUT: begin
          if (lock_cnt >= CNT_W'(LOCKOUT_CYCLES - 1)) begin
            locked_out <= 1'b0;
            fail_count <= 4'd0;
            stage      <= 3'd1;
            lock_cnt   <= '0;
            state      <= WAIT;
          end else lock_cnt <= lock_cnt + CNT_W'(1);
        end
        default: state <= WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: scenario and randomized checks of lock_sequencer against an attempt-level lock model
module tb_lock_sequencer;
  localparam int          MAXF = 3;
  localparam int          LOCKC = 1000;
  localparam int          TOC = 500;
  localparam logic [15:0] CDEF = 16'h0000;
  logic clock = 0, reset = 1;
  logic [3:0] digit_in = 0;
  logic digit_strobe = 0, cypher_load = 0, relock = 0;
  logic [15:0] cypher_in = 0;
  logic dp_valid, dp_invalid, dp_restart, dp_final;
  logic [2:0] control_out, stage;
  logic [3:0] digit_out, fail_count;
  logic [15:0] cypher_out;
  logic dp_read, unlocked, locked_out, busy;
  int checks = 0, errs = 0;
  int m_stage = 1, m_fail = 0;
  bit m_unl = 0, m_lock = 0;
  logic [15:0] m_cy = CDEF;

  lock_sequencer #(.MAX_FAIL(MAXF), .LOCKOUT_CYCLES(LOCKC), .TIMEOUT_CYCLES(TOC),
                   .CYPHER_DEFAULT(CDEF), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .digit_in(digit_in), .digit_strobe(digit_strobe),
    .cypher_load(cypher_load), .cypher_in(cypher_in), .relock(relock),
    .dp_valid(dp_valid), .dp_invalid(dp_invalid), .dp_restart(dp_restart), .dp_final(dp_final),
    .control_out(control_out), .digit_out(digit_out), .cypher_out(cypher_out), .dp_read(dp_read),
    .stage(stage), .fail_count(fail_count), .unlocked(unlocked), .locked_out(locked_out), .busy(busy));

  always #5 clock = ~clock;

  function automatic logic [3:0] dig(input logic [15:0] c, input int k);
    return c[4*k-4 +: 4];
  endfunction

  // datapath stand-in: registers its verdict on the edge that ends the stage-code cycle
  always @(posedge clock or posedge reset)
    if (reset) {dp_valid, dp_invalid, dp_restart, dp_final} <= 4'b0;
    else if (control_out != 0) begin
      dp_valid   <= digit_out == dig(cypher_out, int'(control_out)) && control_out < 4;
      dp_final   <= digit_out == dig(cypher_out, int'(control_out)) && control_out == 4;
      dp_invalid <= digit_out != dig(cypher_out, int'(control_out));
      dp_restart <= control_out >= 2 && digit_out == cypher_out[3:0];
    end

  task automatic model_digit(input logic [3:0] d);
    if (m_lock || m_unl) return;
    if (d == dig(m_cy, m_stage)) begin
      if (m_stage == 4) begin m_unl = 1; m_stage = 1; m_fail = 0; end
      else m_stage++;
    end else if (m_stage >= 2 && d == m_cy[3:0]) m_stage = 2;
    else begin
      m_stage = 1;
      m_fail++;
      if (m_fail == MAXF) m_lock = 1;
    end
  endtask

  task automatic do_digit(input logic [3:0] d);
    int ec;
    ec = (m_lock || m_unl) ? 0 : m_stage;
    @(negedge clock); digit_in = d; digit_strobe = 1;
    @(negedge clock); digit_strobe = 0;
    checks++; if (control_out !== 3'(ec)) begin errs++; $display("FAIL check_ctrl: got %0d want %0d", control_out, ec); end
    checks++; if (dp_read !== (ec != 0)) begin errs++; $display("FAIL check_read: got %0b want %0b", dp_read, ec != 0); end
    checks++; if (busy !== (ec != 0)) begin errs++; $display("FAIL check_busy: got %0b want %0b", busy, ec != 0); end
    @(negedge clock);
    checks++; if (control_out !== 3'd0) begin errs++; $display("FAIL eval_ctrl: got %0d want 0", control_out); end
    @(negedge clock);
    model_digit(d);
    checks++; if (stage !== 3'(m_stage)) begin errs++; $display("FAIL stage: digit %0h got %0d want %0d", d, stage, m_stage); end
    checks++; if (fail_count !== 4'(m_fail)) begin errs++; $display("FAIL fail_count: got %0d want %0d", fail_count, m_fail); end
    checks++; if (unlocked !== m_unl) begin errs++; $display("FAIL unlocked: got %0b want %0b", unlocked, m_unl); end
    checks++; if (locked_out !== m_lock) begin errs++; $display("FAIL locked_out: got %0b want %0b", locked_out, m_lock); end
  endtask

  task automatic do_load(input logic [15:0] v, input bit rel);
    @(negedge clock); cypher_in = v; cypher_load = 1; relock = rel;
    @(negedge clock); cypher_load = 0; relock = 0;
    if (m_unl) begin m_cy = v; if (rel) m_unl = 0; end
    else if (!m_lock && m_stage == 1) m_cy = v;
    checks++; if (cypher_out !== m_cy) begin errs++; $display("FAIL cypher_out: got %0h want %0h", cypher_out, m_cy); end
    checks++; if (unlocked !== m_unl) begin errs++; $display("FAIL relock: got %0b want %0b", unlocked, m_unl); end
  endtask

  task automatic wait_lockout();
    repeat (LOCKC + 10) @(negedge clock);
    m_lock = 0; m_fail = 0; m_stage = 1;
    checks++; if (locked_out !== 1'b0) begin errs++; $display("FAIL lockout_end: got %0b want 0", locked_out); end
    checks++; if (fail_count !== 4'd0) begin errs++; $display("FAIL lockout_fail: got %0d want 0", fail_count); end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clock);
    checks++; if ({control_out, digit_out, dp_read, stage, fail_count, unlocked, locked_out, busy} !== {3'd0, 4'd0, 1'b0, 3'd1, 4'd0, 3'b0})
      begin errs++; $display("FAIL reset_outs: got ctrl=%0d dig=%0h rd=%0b st=%0d fc=%0d u=%0b l=%0b b=%0b", control_out, digit_out, dp_read, stage, fail_count, unlocked, locked_out, busy); end
    checks++; if (cypher_out !== CDEF) begin errs++; $display("FAIL reset_cypher: got %0h want %0h", cypher_out, CDEF); end
    reset = 0;
  endtask

  task automatic test_unlock();
    do_load(16'h4321, 0);
    for (int i = 1; i <= 4; i++) do_digit(4'(i));
    checks++; if (unlocked !== 1'b1) begin errs++; $display("FAIL unlock_seq: got %0b want 1", unlocked); end
    checks++; if (digit_out !== 4'd4) begin errs++; $display("FAIL digit_out: got %0h want 4", digit_out); end
    do_load(16'h4321, 1);
  endtask

  task automatic test_restart();
    logic [3:0] seq [6] = '{1, 2, 1, 2, 3, 4};
    for (int i = 0; i < 6; i++) begin
      do_digit(seq[i]);
      if (i == 2) begin
        checks++; if (stage !== 3'd2) begin errs++; $display("FAIL restart_stage: got %0d want 2", stage); end
      end
    end
    checks++; if (unlocked !== 1'b1) begin errs++; $display("FAIL restart_unlock: got %0b want 1", unlocked); end
    do_load(16'h4321, 1);
  endtask

  task automatic test_lockout();
    for (int i = 0; i < 3; i++) do_digit(4'h9);
    checks++; if (locked_out !== 1'b1 || fail_count !== 4'd3) begin errs++; $display("FAIL lockout_enter: got l=%0b fc=%0d want l=1 fc=3", locked_out, fail_count); end
    do_digit(4'h1);
    repeat (LOCKC - 30) @(negedge clock);
    checks++; if (locked_out !== 1'b1) begin errs++; $display("FAIL lockout_hold: got %0b want 1", locked_out); end
    repeat (40) @(negedge clock);
    m_lock = 0; m_fail = 0; m_stage = 1;
    checks++; if (locked_out !== 1'b0 || fail_count !== 4'd0) begin errs++; $display("FAIL lockout_exit: got l=%0b fc=%0d want 0 0", locked_out, fail_count); end
  endtask

  task automatic test_timeout();
    do_digit(4'h1);
    repeat (TOC - 60) @(negedge clock);
    checks++; if (stage !== 3'd2) begin errs++; $display("FAIL timeout_early: got %0d want 2", stage); end
    repeat (70) @(negedge clock);
    m_stage = 1;
    checks++; if (stage !== 3'd1 || fail_count !== 4'(m_fail)) begin errs++; $display("FAIL timeout: got st=%0d fc=%0d want 1 %0d", stage, fail_count, m_fail); end
    do_digit(4'h1);
  endtask

  task automatic test_cypher();
    do_load(16'hAAAA, 0);
    checks++; if (cypher_out !== 16'h4321) begin errs++; $display("FAIL cypher_locked: got %0h want 4321", cypher_out); end
    do_digit(4'h9);
    do_load(16'hAAAA, 0);
    checks++; if (cypher_out !== 16'hAAAA) begin errs++; $display("FAIL cypher_load: got %0h want aaaa", cypher_out); end
    for (int i = 0; i < 4; i++) do_digit(4'hA);
    do_digit(4'h5);
    do_load(16'h1234, 1);
    checks++; if (unlocked !== 1'b0 || stage !== 3'd1 || cypher_out !== 16'h1234) begin errs++; $display("FAIL relock_load: got u=%0b st=%0d cy=%0h", unlocked, stage, cypher_out); end
  endtask

  task automatic test_reset_check();
    @(negedge clock); digit_in = 4'h4; digit_strobe = 1;
    @(negedge clock); digit_strobe = 0;
    checks++; if (control_out !== 3'd1) begin errs++; $display("FAIL pre_reset_ctrl: got %0d want 1", control_out); end
    #1 reset = 1;
    #1;
    checks++; if (control_out !== 3'd0 || dp_read !== 1'b0 || stage !== 3'd1 || busy !== 1'b0) begin errs++; $display("FAIL async_reset: got ctrl=%0d rd=%0b st=%0d b=%0b", control_out, dp_read, stage, busy); end
    checks++; if (cypher_out !== CDEF) begin errs++; $display("FAIL async_reset_cy: got %0h want %0h", cypher_out, CDEF); end
    @(negedge clock); reset = 0;
    m_stage = 1; m_fail = 0; m_unl = 0; m_lock = 0; m_cy = CDEF;
  endtask

  task automatic test_random();
    logic [3:0] d;
    int r;
    do_load(16'($urandom), 0);
    for (int i = 0; i < 60; i++) begin
      if (m_lock) wait_lockout();
      else if (m_unl) do_load(16'($urandom), 1);
      r = $urandom_range(0, 7);
      if (r == 7 && m_stage == 1 && !m_lock && !m_unl) do_load(16'($urandom), 0);
      d = r < 4 ? dig(m_cy, m_stage) : r < 6 ? m_cy[3:0] : 4'($urandom_range(0, 15));
      do_digit(d);
      repeat ($urandom_range(0, 4)) @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_restart();
    test_lockout();
    test_timeout();
    test_cypher();
    test_reset_check();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
